stopwatch_timebase: RTL and testbench

- Time-keeping core of the stopwatch: converts the system clock into 10 ms ticks and runs a cascaded centisecond/second/minute/hour counter.
- A start/stop/clear state machine controls it, driven by pre-debounced, synchronised push-button levels.
- Produces the binary hours/minutes/seconds/centiseconds fields consumed by the seven-segment display driver, which does its own BCD split.
- Sits between the button conditioning logic and the display.

---
 rtl/stopwatch_timebase.sv | 173 +++++++++++++++++
 tb/tb_stopwatch_timebase.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timebase.sv
// Stopwatch core: 10 ms prescaler, IDLE/RUN/PAUSE control and the hh:mm:ss.cc cascade.
// Define LAP_HOLD_EN to build the lap-hold output freeze (counters keep running underneath).
module stopwatch_timebase #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int TICK_HZ     = 100
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic [6:0] centiseconds,
   output logic       running,
   output logic       overflow,
   output logic       lap_active
);
   localparam int CLKS_PER_TICK = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_TICK - 1);

   if ((CLKS_PER_TICK < 2) || (CLKS_PER_TICK * TICK_HZ != CLK_FREQ_HZ)) begin : g_bad_cfg
      $error("stopwatch_timebase: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

   state_t        state_q, state_d;
   logic          ss_prev_q, clr_prev_q;
   logic [PW-1:0] pre_q, pre_d;
   logic [6:0]    cs_q, cs_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hr_q, hr_d;
   logic          ovf_q, ovf_d;
   logic          ss_edge, clr_edge, tick;

   assign ss_edge  = btn_start_stop & ~ss_prev_q;
   assign clr_edge = btn_clear & ~clr_prev_q;
   assign tick     = (state_q == RUN) && (pre_q == PRE_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ss_prev_q  <= 1'b0;
         clr_prev_q <= 1'b0;
         pre_q      <= '0;
         cs_q       <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         hr_q       <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ss_prev_q  <= btn_start_stop;
         clr_prev_q <= btn_clear;
         pre_q      <= pre_d;
         cs_q       <= cs_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hr_q       <= hr_d;
         ovf_q      <= ovf_d;
      end
   end

   // Clear overrides everything; otherwise the tick is counted even when start_stop pauses.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cs_d    = cs_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hr_d    = hr_q;
      ovf_d   = ovf_q;
      if (clr_edge) begin
         state_d = IDLE;
         pre_d   = '0;
         cs_d    = '0;
         sec_d   = '0;
         min_d   = '0;
         hr_d    = '0;
         ovf_d   = 1'b0;
      end else begin
         if (state_q == RUN) pre_d = tick ? '0 : pre_q + 1'b1;
         if (tick) begin
            if (cs_q == 7'd99) begin
               cs_d = '0;
               if (sec_q == 6'd59) begin
                  sec_d = '0;
                  if (min_q == 6'd59) begin
                     min_d = '0;
                     if (hr_q == 5'd23) begin
                        hr_d  = '0;
                        ovf_d = 1'b1;
                     end else begin
                        hr_d = hr_q + 5'd1;
                     end
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end else begin
               cs_d = cs_q + 7'd1;
            end
         end
         if (ss_edge) begin
            case (state_q)
               IDLE:    state_d = RUN;
               RUN:     state_d = PAUSE;
               PAUSE:   state_d = RUN;
               default: state_d = IDLE;
            endcase
         end
      end
   end

   assign running  = (state_q == RUN);
   assign overflow = ovf_q;

`ifdef LAP_HOLD_EN
   logic       lap_prev_q, lap_q, lap_d, lap_edge;
   logic [6:0] snap_cs_q;
   logic [5:0] snap_sec_q, snap_min_q;
   logic [4:0] snap_hr_q;

   assign lap_edge = btn_lap & ~lap_prev_q;

   always_comb begin
      lap_d = lap_q;
      if (clr_edge)      lap_d = 1'b0;
      else if (lap_edge) lap_d = (state_q == RUN) ? ~lap_q : 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lap_prev_q <= 1'b0;
         lap_q      <= 1'b0;
      end else begin
         lap_prev_q <= btn_lap;
         lap_q      <= lap_d;
      end
   end

   // Snapshot is the time on display at the instant hold engages.
   always_ff @(posedge clock) begin
      if (lap_edge && !lap_q && !clr_edge && (state_q == RUN)) begin
         snap_cs_q  <= cs_q;
         snap_sec_q <= sec_q;
         snap_min_q <= min_q;
         snap_hr_q  <= hr_q;
      end
   end

   assign hours        = lap_q ? snap_hr_q  : hr_q;
   assign minutes      = lap_q ? snap_min_q : min_q;
   assign seconds      = lap_q ? snap_sec_q : sec_q;
   assign centiseconds = lap_q ? snap_cs_q  : cs_q;
   assign lap_active   = lap_q;
`else
   logic unused_lap;
   assign unused_lap   = btn_lap;
   assign hours        = hr_q;
   assign minutes      = min_q;
   assign seconds      = sec_q;
   assign centiseconds = cs_q;
   assign lap_active   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Bench for stopwatch_timebase: elapsed-time model in centiseconds plus directed literal checks.
module tb_stopwatch_timebase;
   localparam int N   = 10;
   localparam int DAY = 24 * 60 * 60 * 100;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
   logic [4:0] hours;
   logic [5:0] minutes, seconds;
   logic [6:0] centiseconds;
   logic       running, overflow, lap_active;

   int checks = 0;
   int errors = 0;

   int m_cs = 0, m_pre = 0, m_state = 0, m_snap = 0;
   bit m_ovf = 0, m_lap = 0;
   bit p_ss = 0, p_clr = 0, p_lap = 0;
   bit force_now = 0;

   always #5 clock = ~clock;

   stopwatch_timebase #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
      .clock(clock), .reset_n(reset_n),
      .btn_start_stop(btn_ss), .btn_clear(btn_clr), .btn_lap(btn_lap),
      .hours(hours), .minutes(minutes), .seconds(seconds), .centiseconds(centiseconds),
      .running(running), .overflow(overflow), .lap_active(lap_active)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Model: elapsed time as one integer count of centiseconds; state 0=idle 1=run 2=pause.
   initial forever begin : model
      bit e_ss, e_clr, e_lap;
      int st0;
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
         m_cs = 0; m_pre = 0; m_state = 0; m_ovf = 0; m_lap = 0;
         p_ss = 0; p_clr = 0; p_lap = 0;
      end else begin
         if (force_now) m_cs = DAY - 1;
         e_ss  = btn_ss && !p_ss;
         e_clr = btn_clr && !p_clr;
         e_lap = btn_lap && !p_lap;
         p_ss = btn_ss; p_clr = btn_clr; p_lap = btn_lap;
         if (e_clr) begin
            m_state = 0; m_cs = 0; m_pre = 0; m_ovf = 0; m_lap = 0;
         end else begin
            st0 = m_state;
`ifdef LAP_HOLD_EN
            if (e_lap) begin
               if (st0 == 1) begin
                  if (!m_lap) m_snap = m_cs;
                  m_lap = !m_lap;
               end else begin
                  m_lap = 0;
               end
            end
`endif
            if (st0 == 1) begin
               if (m_pre == N - 1) begin
                  m_pre = 0;
                  m_cs  = m_cs + 1;
                  if (m_cs == DAY) begin
                     m_cs  = 0;
                     m_ovf = 1;
                  end
               end else begin
                  m_pre = m_pre + 1;
               end
            end
            if (e_ss) m_state = (st0 == 1) ? 2 : 1;
         end
      end
   end

   initial forever begin : compare
      int shown;
      @(posedge clock);
      #1;
      if (reset_n) begin
         shown = m_lap ? m_snap : m_cs;
         chk("model hours",        int'(hours),        shown / 360000);
         chk("model minutes",      int'(minutes),      (shown / 6000) % 60);
         chk("model seconds",      int'(seconds),      (shown / 100) % 60);
         chk("model centiseconds", int'(centiseconds), shown % 100);
         chk("model running",      int'(running),      (m_state == 1) ? 1 : 0);
         chk("model overflow",     int'(overflow),     int'(m_ovf));
         chk("model lap_active",   int'(lap_active),   int'(m_lap));
      end
   end

   initial begin
      cyc(3);
      chk("reset hours", int'(hours), 0);
      chk("reset minutes", int'(minutes), 0);
      chk("reset seconds", int'(seconds), 0);
      chk("reset centiseconds", int'(centiseconds), 0);
      chk("reset running", int'(running), 0);
      chk("reset overflow", int'(overflow), 0);
      chk("reset lap_active", int'(lap_active), 0);
      reset_n = 1'b1;
      cyc(2);

      // first increment lands 10 cycles after running rises
      btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
      chk("t1 running", int'(running), 1);
      cyc(9);
      chk("t1 cs before tick", int'(centiseconds), 0);
      cyc(1);
      chk("t1 first tick", int'(centiseconds), 1);
      cyc(1000);
      chk("t1 seconds", int'(seconds), 1);
      chk("t1 centiseconds", int'(centiseconds), 1);

      // pause keeps prescaler phase
      btn_clr = 1'b1; cyc(1); btn_clr = 1'b0;
      chk("t2 cleared running", int'(running), 0);
      chk("t2 cleared seconds", int'(seconds), 0);
      btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
      cyc(250);
      chk("t2 at 25", int'(centiseconds), 25);
      btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
      chk("t2 paused", int'(running), 0);
      cyc(200);
      chk("t2 held in pause", int'(centiseconds), 25);
      btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
      chk("t2 resumed", int'(running), 1);
      cyc(8);
      chk("t2 residual not yet", int'(centiseconds), 25);
      cyc(1);
      chk("t2 residual tick", int'(centiseconds), 26);

      // wrap from 23:59:59.99
      btn_clr = 1'b1; cyc(1); btn_clr = 1'b0;
      force dut.hr_q  = 5'd23;
      force dut.min_q = 6'd59;
      force dut.sec_q = 6'd59;
      force dut.cs_q  = 7'd99;
      force_now = 1'b1;
      cyc(1);
      force_now = 1'b0;
      release dut.hr_q;
      release dut.min_q;
      release dut.sec_q;
      release dut.cs_q;
      chk("t3 loaded hours", int'(hours), 23);
      chk("t3 loaded cs", int'(centiseconds), 99);
      btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
      cyc(9);
      chk("t3 pre-wrap minutes", int'(minutes), 59);
      cyc(1);
      chk("t3 wrap hours", int'(hours), 0);
      chk("t3 wrap minutes", int'(minutes), 0);
      chk("t3 wrap seconds", int'(seconds), 0);
      chk("t3 wrap cs", int'(centiseconds), 0);
      chk("t3 overflow set", int'(overflow), 1);
      cyc(3420);
      chk("t3 seconds 3", int'(seconds), 3);
      chk("t3 cs 42", int'(centiseconds), 42);
      chk("t3 overflow sticky", int'(overflow), 1);

      // clear beats start_stop
      btn_ss = 1'b1; btn_clr = 1'b1; cyc(1); btn_ss = 1'b0; btn_clr = 1'b0;
      chk("t4 running", int'(running), 0);
      chk("t4 seconds", int'(seconds), 0);
      chk("t4 cs", int'(centiseconds), 0);
      chk("t4 overflow", int'(overflow), 0);
      cyc(20);
      chk("t4 stays idle", int'(centiseconds), 0);

      // held button gives one edge
      btn_ss = 1'b1; cyc(50);
      chk("t5 running while held", int'(running), 1);
      chk("t5 cs after 50", int'(centiseconds), 4);
      btn_ss = 1'b0; cyc(5);
      chk("t5 still running", int'(running), 1);

      btn_clr = 1'b1; cyc(1); btn_clr = 1'b0;
      btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
      cyc(1070);
      chk("t6 at 1.07", int'(centiseconds), 7);
      btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
`ifdef LAP_HOLD_EN
      chk("t6 lap on", int'(lap_active), 1);
      cyc(299);
      chk("t6 frozen seconds", int'(seconds), 1);
      chk("t6 frozen cs", int'(centiseconds), 7);
      btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
      chk("t6 lap off", int'(lap_active), 0);
      chk("t6 live seconds", int'(seconds), 1);
      chk("t6 live cs", int'(centiseconds), 37);
`else
      chk("t6 lap ignored", int'(lap_active), 0);
      cyc(299);
      chk("t6 live cs", int'(centiseconds), 37);
`endif
      cyc(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
